// File: rtl/fpnew_result_reorder_pkg.sv
// rtl/fpnew_result_reorder_pkg.sv - shared types for the FPU result reorder block
package fpnew_result_reorder_pkg;

    localparam int unsigned DEFAULT_WIDTH     = 32;
    localparam int unsigned DEFAULT_TAG_WIDTH = 2;

    // IEEE exception flags in FPU order: invalid, div-by-zero, overflow, underflow, inexact
    typedef struct packed {
        logic nv;
        logic dz;
        logic of;
        logic uf;
        logic nx;
    } status_t;

endpackage

// File: rtl/fpnew_result_reorder_if.sv
// rtl/fpnew_result_reorder_if.sv - issue, result and output handshakes of the reorder block
interface fpnew_result_reorder_if #(
    parameter int unsigned Width    = 32,
    parameter int unsigned TagWidth = 2
);
    import fpnew_result_reorder_pkg::*;

    logic                issue_valid_i;
    logic                issue_ready_o;
    logic [TagWidth-1:0] issue_tag_o;

    logic                res_valid_i;
    logic                res_ready_o;
    logic [Width-1:0]    res_result_i;
    status_t             res_status_i;
    logic                res_ext_bit_i;
    logic [TagWidth-1:0] res_tag_i;

    logic                out_valid_o;
    logic                out_ready_i;
    logic [Width-1:0]    out_result_o;
    status_t             out_status_o;
    logic                out_ext_bit_o;
    logic [TagWidth-1:0] out_tag_o;

    // Issue/writeback side of the FPU driving the reorder block
    modport master (
        output issue_valid_i, input issue_ready_o, input issue_tag_o,
        output res_valid_i, input res_ready_o, output res_result_i,
        output res_status_i, output res_ext_bit_i, output res_tag_i,
        input out_valid_o, output out_ready_i, input out_result_o,
        input out_status_o, input out_ext_bit_o, input out_tag_o
    );

    // The reorder block itself
    modport slave (
        input issue_valid_i, output issue_ready_o, output issue_tag_o,
        input res_valid_i, output res_ready_o, input res_result_i,
        input res_status_i, input res_ext_bit_i, input res_tag_i,
        output out_valid_o, input out_ready_i, output out_result_o,
        output out_status_o, output out_ext_bit_o, output out_tag_o
    );

endinterface

// File: rtl/fpnew_result_reorder.sv
// rtl/fpnew_result_reorder.sv - tag allocator and in-order result collector for one opgroup
module fpnew_result_reorder
    import fpnew_result_reorder_pkg::*;
#(
    parameter int unsigned Width    = DEFAULT_WIDTH,
    parameter int unsigned TagWidth = DEFAULT_TAG_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    fpnew_result_reorder_if.slave bus,
    output logic                  tag_err_o,
    output logic                  busy_o
);

    localparam int unsigned NumTags = 2 ** TagWidth;
    localparam logic [TagWidth:0] PtrOne = {{TagWidth{1'b0}}, 1'b1};

    typedef struct packed {
        logic [Width-1:0] result;
        status_t          status;
        logic             ext_bit;
    } reorder_entry_t;

    // Pointers carry an extra wrap bit so full and empty are distinguishable
    logic [TagWidth:0]    head_q, tail_q;
    logic [NumTags-1:0]   alloc_q, done_q;
    reorder_entry_t       entries_q [NumTags];
    logic                 err_q;

    logic [TagWidth-1:0]  head_idx, tail_idx;
    logic                 empty, full;
    logic                 issue_fire, retire, res_ok;

    assign head_idx = head_q[TagWidth-1:0];
    assign tail_idx = tail_q[TagWidth-1:0];
    assign empty    = (head_q == tail_q);
    assign full     = (head_idx == tail_idx) && (head_q[TagWidth] != tail_q[TagWidth]);

    // A result is only legal for a slot that was issued and has not yet returned
    assign res_ok     = bus.res_valid_i && alloc_q[bus.res_tag_i] && !done_q[bus.res_tag_i];
    assign issue_fire = bus.issue_valid_i && !full;
    assign retire     = bus.out_valid_o && bus.out_ready_i;

    assign bus.issue_ready_o = !full;
    assign bus.issue_tag_o   = tail_idx;
    assign bus.res_ready_o   = 1'b1;

    // Output is always taken from the head slot's flops; no same-cycle bypass
    assign bus.out_valid_o   = !empty && done_q[head_idx];
    assign bus.out_result_o  = entries_q[head_idx].result;
    assign bus.out_status_o  = entries_q[head_idx].status;
    assign bus.out_ext_bit_o = entries_q[head_idx].ext_bit;
    assign bus.out_tag_o     = head_idx;

    assign tag_err_o = err_q;
    assign busy_o    = !empty;

    // Pointer, flag and error bookkeeping; flush overrides every other event
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head_q  <= '0;
            tail_q  <= '0;
            alloc_q <= '0;
            done_q  <= '0;
            err_q   <= 1'b0;
        end else if (flush_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            alloc_q <= '0;
            done_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            err_q <= bus.res_valid_i && !res_ok;
            // Retire and issue never hit the same slot: retiring implies non-empty, issuing implies non-full
            if (retire) begin
                alloc_q[head_idx] <= 1'b0;
                done_q[head_idx]  <= 1'b0;
                head_q            <= head_q + PtrOne;
            end
            if (issue_fire) begin
                alloc_q[tail_idx] <= 1'b1;
                done_q[tail_idx]  <= 1'b0;
                tail_q            <= tail_q + PtrOne;
            end
            if (res_ok) begin
                done_q[bus.res_tag_i] <= 1'b1;
            end
        end
    end

    // Result payload storage; contents are meaningless until the done flag is set
    always_ff @(posedge clk_i) begin
        if (res_ok && !flush_i) begin
            entries_q[bus.res_tag_i] <= '{result:  bus.res_result_i,
                                         status:  bus.res_status_i,
                                         ext_bit: bus.res_ext_bit_i};
        end
    end

endmodule

// File: tb/tb_fpnew_result_reorder.sv
// tb/tb_fpnew_result_reorder.sv - scoreboard bench for the FPU result reorder block
module tb_fpnew_result_reorder;
    import fpnew_result_reorder_pkg::*;

    localparam int W  = 32;
    localparam int TW = 2;
    localparam int NT = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    logic tag_err, busy;

    always #5 clk = ~clk;

    fpnew_result_reorder_if #(.Width(W), .TagWidth(TW)) bus ();

    fpnew_result_reorder #(.Width(W), .TagWidth(TW)) dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .flush_i   (flush),
        .bus       (bus),
        .tag_err_o (tag_err),
        .busy_o    (busy)
    );

    // Reference model: operations in issue order, each filled in when its result returns
    typedef struct {
        int          tag;
        bit          done;
        logic [31:0] result;
        logic [4:0]  status;
        logic        ext;
    } op_t;

    op_t mq[$];
    int  next_tag = 0;
    bit  err_exp  = 0;
    int  checks   = 0;
    int  errors   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit exp_valid();
        return (mq.size() > 0) && mq[0].done;
    endfunction

    // Model update on each active edge from the inputs presented during that cycle
    always @(posedge clk) begin
        bit ret;
        bit can_issue;
        int idx;
        op_t n;
        if (!rst_n) begin
            mq.delete();
            next_tag = 0;
            err_exp  = 0;
        end else if (flush) begin
            mq.delete();
            next_tag = 0;
            err_exp  = 0;
        end else begin
            ret       = exp_valid() && bus.out_ready_i;
            can_issue = mq.size() < NT;
            idx       = -1;
            if (bus.res_valid_i)
                for (int i = 0; i < mq.size(); i++)
                    if (mq[i].tag == int'(bus.res_tag_i) && !mq[i].done) idx = i;
            err_exp = bus.res_valid_i && (idx < 0);
            if (idx >= 0) begin
                mq[idx].done   = 1;
                mq[idx].result = bus.res_result_i;
                mq[idx].status = bus.res_status_i;
                mq[idx].ext    = bus.res_ext_bit_i;
            end
            if (ret) void'(mq.pop_front());
            if (bus.issue_valid_i && can_issue) begin
                n.tag    = next_tag;
                n.done   = 0;
                n.result = '0;
                n.status = '0;
                n.ext    = 1'b0;
                mq.push_back(n);
                next_tag = (next_tag + 1) % NT;
            end
        end
    end

    // Monitor: compare every DUT output against the model away from the active edge
    always @(negedge clk) begin
        check("issue_ready", 64'(bus.issue_ready_o), 64'(mq.size() < NT));
        check("issue_tag",   64'(bus.issue_tag_o),   64'(next_tag));
        check("busy",        64'(busy),              64'(mq.size() > 0));
        check("tag_err",     64'(tag_err),           64'(err_exp));
        check("res_ready",   64'(bus.res_ready_o),   64'(1));
        check("out_valid",   64'(bus.out_valid_o),   64'(exp_valid()));
        if (bus.out_valid_o && exp_valid()) begin
            check("out_tag",    64'(bus.out_tag_o),    64'(mq[0].tag));
            check("out_result", 64'(bus.out_result_o), 64'(mq[0].result));
            check("out_status", 64'(bus.out_status_o), 64'(mq[0].status));
            check("out_ext",    64'(bus.out_ext_bit_o), 64'(mq[0].ext));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.issue_valid_i = 1'b0;
        bus.res_valid_i   = 1'b0;
        flush             = 1'b0;
    endtask

    task automatic issue_n(input int n);
        bus.issue_valid_i = 1'b1;
        repeat (n) tick();
        bus.issue_valid_i = 1'b0;
    endtask

    task automatic send(input int tag, input logic [31:0] data);
        bus.res_valid_i   = 1'b1;
        bus.res_tag_i     = tag[TW-1:0];
        bus.res_result_i  = data;
        bus.res_status_i  = 5'($urandom);
        bus.res_ext_bit_i = 1'($urandom);
        tick();
        bus.res_valid_i   = 1'b0;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tick();
    endtask

    int pick;
    int cand[$];

    initial begin
        bus.issue_valid_i = 1'b0;
        bus.res_valid_i   = 1'b0;
        bus.res_result_i  = '0;
        bus.res_status_i  = '0;
        bus.res_ext_bit_i = 1'b0;
        bus.res_tag_i     = '0;
        bus.out_ready_i   = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // In-order return
        bus.out_ready_i = 1'b1;
        issue_n(3);
        send(0, 32'hA0); send(1, 32'hA1); send(2, 32'hA2);
        repeat (3) tick();

        // Out-of-order return, nothing emitted until tag 0 arrives
        do_flush();
        issue_n(4);
        send(3, 32'h33); send(1, 32'h11); send(2, 32'h22);
        repeat (2) tick();
        send(0, 32'h00);
        repeat (6) tick();

        // Full, then retire while issue is held: issue proceeds with wrapped tag 0
        do_flush();
        bus.out_ready_i = 1'b0;
        issue_n(4);
        bus.issue_valid_i = 1'b1;
        send(0, 32'h5A5A);
        tick();
        bus.out_ready_i = 1'b1;
        tick();
        bus.out_ready_i = 1'b0;
        tick();
        bus.issue_valid_i = 1'b0;
        bus.out_ready_i = 1'b1;
        send(1, 32'h1); send(2, 32'h2); send(3, 32'h3); send(0, 32'h4);
        repeat (4) tick();

        // Bad tag: only tag 0 outstanding
        do_flush();
        issue_n(1);
        send(2, 32'hDEAD);
        tick();
        send(0, 32'hBEEF);
        repeat (3) tick();

        // Flush with three outstanding, one done
        do_flush();
        bus.out_ready_i = 1'b0;
        issue_n(3);
        send(1, 32'h77);
        do_flush();
        issue_n(1);
        bus.out_ready_i = 1'b1;
        send(0, 32'h99);
        repeat (2) tick();

        // Backpressure on a done head; later tag 1 stored but not emitted early
        do_flush();
        bus.out_ready_i = 1'b0;
        issue_n(2);
        send(0, 32'hC0);
        repeat (5) tick();
        send(1, 32'hC1);
        repeat (2) tick();
        bus.out_ready_i = 1'b1;
        repeat (3) tick();

        // Randomised traffic
        for (int c = 0; c < 3000; c++) begin
            bus.issue_valid_i = 1'($urandom_range(0, 1));
            bus.out_ready_i   = ($urandom_range(0, 3) != 0);
            flush             = ($urandom_range(0, 63) == 0);
            bus.res_valid_i   = 1'b0;
            cand.delete();
            foreach (mq[i]) if (!mq[i].done) cand.push_back(mq[i].tag);
            if ($urandom_range(0, 9) == 0) begin
                bus.res_valid_i = 1'b1;
                bus.res_tag_i   = 2'($urandom);
            end else if (cand.size() > 0 && $urandom_range(0, 1) == 1) begin
                pick            = cand[$urandom_range(0, cand.size() - 1)];
                bus.res_valid_i = 1'b1;
                bus.res_tag_i   = pick[TW-1:0];
            end
            bus.res_result_i  = $urandom;
            bus.res_status_i  = 5'($urandom);
            bus.res_ext_bit_i = 1'($urandom);
            tick();
        end

        // Drain whatever is still in flight
        idle();
        bus.out_ready_i = 1'b1;
        for (int c = 0; c < 40 && mq.size() > 0; c++) begin
            cand.delete();
            foreach (mq[i]) if (!mq[i].done) cand.push_back(mq[i].tag);
            if (cand.size() > 0) send(cand[0], $urandom);
            else tick();
        end
        repeat (4) tick();
        check("drained_busy", 64'(busy), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
